multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start_valid  input  1  the operand set is valid.
REQ-005 SHALL have port start_ready  output  1  the block can accept an operand set.
REQ-006 SHALL have port a  input  W  operand A, sampled at start handshake.
REQ-007 SHALL have port b  input  W  operand B, sampled at start handshake.
REQ-008 SHALL have port cin  input  1  carry-in, sampled at start handshake; ignored when sub=1.
REQ-009 SHALL have port sub  input  1  0 selects A+B+cin, 1 selects A-B; sampled at start handshake.
REQ-010 SHALL have port res_valid  output  1  the result is valid.
REQ-011 SHALL have port res_ready  input  1  the consumer accepts the result.
REQ-012 SHALL have port sum  output  W  the result word.
REQ-013 SHALL have port cout  output  1  carry out of the top slice; for sub=1, cout=1 means no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive start_ready=1 only in IDLE and res_valid=1 only in DONE.
REQ-017 SHALL, on a start handshake (start_valid && start_ready), latch a, b (or ~b when sub=1), carry=(sub ? 1 : cin), clear slice counter, and go IDLE->RUN.
REQ-018 SHALL, in RUN, add slice i of A, slice i of B' and the carry register in one cycle (LSB slice first), store the 4-bit result into slice i of sum, update carry, and increment i.
REQ-019 SHALL transition RUN->DONE on the edge that processes slice NIBBLES-1; res_valid SHALL rise exactly NIBBLES cycles after the handshake edge.
REQ-020 SHALL compute ovf = carry into top bit XOR carry out of top bit, evaluated in the final slice.
REQ-021 SHALL hold sum, cout and ovf stable in DONE until res_valid && res_ready, then go DONE->IDLE.
REQ-022 SHALL NOT accept a new operand set in the DONE cycle that retires the result; the earliest next handshake is the following cycle.
REQ-023 SHALL ignore changes on a, b, cin and sub outside the handshake cycle.
REQ-024 SHALL ignore start_valid in RUN and DONE; no request is queued.
REQ-025 SHALL keep sum, cout and ovf holding the last completed result while in IDLE.

Reset
REQ-026 SHALL, on rst assertion in any state including mid-RUN, immediately force IDLE, start_ready=1, res_valid=0, sum=0, cout=0, ovf=0, counter=0 and carry=0.
REQ-027 SHALL discard any partial computation on reset, with no result emitted.

Configuration
REQ-028 SHALL compile overflow logic only when macro MULTIWORD_ADD_SEQ_OVF_EN is defined.
REQ-029 SHALL, with MULTIWORD_ADD_SEQ_OVF_EN undefined, keep the ovf port and tie it to constant 0.

Structure
REQ-030 SHALL place the FSM state enum, the slice width constant (4) and the default NIBBLES in shared package multiword_add_pkg.
REQ-031 SHALL implement the state register, counter and next-state logic in sub-module multiword_add_fsm; the parent holds the operand/result registers and the slice datapath.

Verification
REQ-032 SHALL verify basic carry: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles, sum=0x0100, cout=0, ovf=0.
REQ-033 SHALL verify full wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; with cin=1 -> sum=0x0001, cout=1.
REQ-034 SHALL verify subtract and overflow: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; sub=0, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (ovf=0 with the macro undefined).
REQ-035 SHALL verify backpressure: res_ready=0 for 5 cycles -> res_valid, sum, cout and ovf held constant and start_ready=0; res_ready=1 -> IDLE next cycle.
REQ-036 SHALL verify reset mid-RUN: rst pulsed at slice 2 -> outputs zero, start_ready=1, and no res_valid pulse; the next request a=0x1234, b=0x1111 -> sum=0x2345.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared definitions for the nibble-serial multiword adder/subtractor.
// Optional overflow logic is enabled with MULTIWORD_ADD_SEQ_OVF_EN.
package multiword_add_pkg;

  localparam int unsigned SLICE_W     = 4;
  localparam int unsigned NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/multiword_add_fsm.sv
// Control FSM for multiword_add_seq: state register, slice counter and handshakes.
// Overflow enable (MULTIWORD_ADD_SEQ_OVF_EN) does not affect this file.
module multiword_add_fsm
  import multiword_add_pkg::*;
#(
  parameter int unsigned NIBBLES = NIBBLES_DEF,
  parameter int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  input  logic             res_ready_i,
  output logic             start_ready_o,
  output logic             res_valid_o,
  output logic             load_o,
  output logic             step_o,
  output logic             last_o,
  output logic [CNT_W-1:0] idx_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    load_o        = 1'b0;
    step_o        = 1'b0;
    last_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step_o = 1'b1;
        if (cnt_q == CNT_W'(NIBBLES - 1)) begin
          last_o  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_o = cnt_q;

endmodule

// File: rtl/multiword_add_seq.sv
// Nibble-serial A+B+cin / A-B engine with valid/ready start and result handshakes.
// Define MULTIWORD_ADD_SEQ_OVF_EN to build signed-overflow logic; otherwise ovf is tied to 0.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int unsigned NIBBLES = NIBBLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic             load, step, last;
  logic [CNT_W-1:0] idx;

  multiword_add_fsm #(
    .NIBBLES (NIBBLES),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .start_valid_i (start_valid),
    .res_ready_i   (res_ready),
    .start_ready_o (start_ready),
    .res_valid_o   (res_valid),
    .load_o        (load),
    .step_o        (step),
    .last_o        (last),
    .idx_o         (idx)
  );

  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   slice_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Subtraction is A + ~B + 1, so B is inverted once at load and carry seeded to 1.
  always_comb begin
    a_sl      = a_q[idx*SLICE_W +: SLICE_W];
    b_sl      = b_q[idx*SLICE_W +: SLICE_W];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    if (load) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub | cin;
    end else if (step) begin
      sum_d[idx*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
      carry_d                       = slice_res[SLICE_W];
      if (last) cout_d = slice_res[SLICE_W];
    end
  end

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  // Carry into the top bit is recovered from the top sum bit and its operand bits.
  always_comb begin
    ovf_d = ovf_q;
    if (step && last)
      ovf_d = (a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ slice_res[SLICE_W-1]) ^ slice_res[SLICE_W];
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq (default NIBBLES=4) against an integer model.
// Expected ovf follows MULTIWORD_ADD_SEQ_OVF_EN.
module tb_multiword_add_seq;

  localparam int unsigned N = 4;

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        start_valid, start_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub;
  logic        res_valid, res_ready;
  logic        cout, ovf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  multiword_add_seq #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic co, output logic ov);
    int u, sa, sbv, r;
    sa  = av[15] ? int'(av) - 65536 : int'(av);
    sbv = bv[15] ? int'(bv) - 65536 : int'(bv);
    if (sb) begin
      u = int'(av) - int'(bv) + 65536;
      r = sa - sbv;
    end else begin
      u = int'(av) + int'(bv) + int'(ci);
      r = sa + sbv + int'(ci);
    end
    s  = u[15:0];
    co = (u >= 65536);
    ov = OVF_EN && ((r > 32767) || (r < -32768));
  endfunction

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic sb, input int unsigned hold,
                       output logic [15:0] so, output logic co, output logic ov);
    logic [15:0] es;
    logic        ec, eo;
    int unsigned cyc;
    model(av, bv, ci, sb, es, ec, eo);
    cyc = 0;
    while (!start_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("start_ready_idle", start_ready, 1);
    a = av; b = bv; cin = ci; sub = sb; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check_eq("start_ready_run", start_ready, 0);
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      start_valid = 1'($urandom);
      @(posedge clk); #1; cyc++;
    end
    start_valid = 1'b0;
    check_eq("latency", cyc, N);
    check_eq("sum", sum, es);
    check_eq("cout", cout, ec);
    check_eq("ovf", ovf, eo);
    so = sum; co = cout; ov = ovf;
    for (int unsigned h = 0; h < hold; h++) begin
      start_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_sum", sum, es);
      check_eq("hold_cout", cout, ec);
      check_eq("hold_ovf", ovf, eo);
      check_eq("hold_start_ready", start_ready, 0);
    end
    // Retire with a fresh request present: it must not be taken on this edge.
    res_ready = 1'b1; start_valid = 1'b1;
    a = 16'($urandom); b = 16'($urandom);
    @(posedge clk); #1;
    res_ready = 1'b0; start_valid = 1'b0;
    check_eq("retire_valid", res_valid, 0);
    check_eq("retire_start_ready", start_ready, 1);
    check_eq("idle_sum_kept", sum, es);
  endtask

  initial begin
    logic [15:0] s;
    logic        c, o;
    logic        seen;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #2;
    check_eq("rst_start_ready", start_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    rst = 1'b0;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, s, c, o);
    check_eq("d_carry_sum", s, 16'h0100);
    check_eq("d_carry_cout", c, 0);
    check_eq("d_carry_ovf", o, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s, c, o);
    check_eq("d_wrap_sum", s, 16'h0000);
    check_eq("d_wrap_cout", c, 1);
    check_eq("d_wrap_ovf", o, 0);
    do_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, s, c, o);
    check_eq("d_wrapc_sum", s, 16'h0001);
    check_eq("d_wrapc_cout", c, 1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, s, c, o);
    check_eq("d_sub_sum", s, 16'hFFFE);
    check_eq("d_sub_cout", c, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5, s, c, o);
    check_eq("d_ovf_sum", s, 16'h8000);
    check_eq("d_ovf_ovf", o, OVF_EN);

    // Reset in the middle of RUN, after slices 0 and 1 have been processed.
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_start_ready", start_ready, 1);
    check_eq("mid_rst_res_valid", res_valid, 0);
    check_eq("mid_rst_sum", sum, 0);
    check_eq("mid_rst_cout", cout, 0);
    check_eq("mid_rst_ovf", ovf, 0);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      seen = seen | res_valid;
    end
    check_eq("mid_rst_no_result", seen, 0);
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, s, c, o);
    check_eq("post_rst_sum", s, 16'h2345);

    for (int unsigned i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) ra = 16'hFFFF;
      if (i % 8 == 1) rb = 16'h8000;
      if (i % 8 == 2) rb = ra;
      do_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), s, c, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
